mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory request port between the I-cache (requester I) and the D-cache (requester D).
//  Each cache's Allocate and WriteBack traffic arrives on a valid/ready channel and is serialised onto one memory channel.
//  Conflicts are resolved round-robin, and exactly one memory transaction is outstanding at any time.
//  Sits between the two cache controllers and the memory model/controller.
// PARAMETERS
//  ADDR_W     32  address width, all channels
//  DATA_W     32  data width, all channels
//  RR_EN      1   1: round-robin on conflict; 0: fixed priority, D always wins
//  MAX_WAIT   255 cycles a granted txn may wait for mem_req_ready before err_timeout pulses
// PORTS
//  clk              in   1       clock, all logic on posedge
//  rst              in   1       synchronous, active-low reset
//  i_req_valid      in   1       I-cache request
//  i_req_wr         in   1       I-cache write (1) / read (0)
//  i_req_addr       in   ADDR_W  I-cache address
//  i_wr_data        in   DATA_W  I-cache write data
//  i_req_ready      out  1       1-cycle completion pulse to I-cache
//  i_rd_data        out  DATA_W  read data; valid only while i_req_ready=1
//  d_req_valid, d_req_wr, d_req_addr, d_wr_data, d_req_ready, d_rd_data   same as I-side, for D-cache
//  mem_req_addr     out  ADDR_W  registered address to memory
//  mem_wr_data      out  DATA_W  registered write data to memory
//  mem_req_vaild    out  1       request valid to memory, held until ready
//  mem_req_wr       out  1       write (1) / read (0)
//  mem_req_data     in   DATA_W  memory read data, valid with mem_req_ready
//  mem_req_ready    in   1       1-cycle completion pulse from memory
//  grant_d          out  1       owner of current/last txn (0=I, 1=D), debug
//  err_timeout      out  1       1-cycle pulse when wait counter reaches MAX_WAIT
// BEHAVIOUR
//  Reset (rst=0 at posedge) forces the following; any in-flight txn is dropped, with no ready to either cache:
//   state=IDLE; all outputs=0; last_grant=I, so D wins the first conflict; wait_cnt=0.
//  FSM states: IDLE, ISSUE, WAIT.
//  IDLE: a requester is sampled if its valid=1.
//   Only I valid: grant I. Only D valid: grant D. Neither: stay in IDLE.
//   Both valid: grant the requester other than last_grant when RR_EN=1; grant D when RR_EN=0.
//   On a grant, latch the winner's addr/wr/data into the mem_* registers, set grant_d, and go to ISSUE.
//  ISSUE: mem_req_vaild=1 in this cycle, i.e. 1 cycle after the IDLE sample. Go to WAIT.
//  WAIT: mem_req_vaild stays 1 and the mem_* outputs stay stable; wait_cnt increments each cycle.
//   When mem_req_ready=1:
//    - the owner's *_req_ready=1 combinationally in the same cycle;
//    - *_rd_data = mem_req_data, whether the txn is a read or a write;
//    - the other requester's ready stays 0;
//    - mem_req_vaild clears at the next edge; last_grant <= owner; wait_cnt <= 0; go to IDLE.
//   When wait_cnt == MAX_WAIT: err_timeout pulses once; the txn keeps waiting and is not aborted.
//  mem_req_ready seen in IDLE or ISSUE is ignored.
//  Non-owner *_rd_data = 0.
//  Minimum latency from request to ready is 3 cycles: IDLE sample, ISSUE, WAIT with ready.
//  Re-arbitration happens in the IDLE cycle after each completion; no back-to-back issue.
//  Requesters hold valid until their ready. The arbiter uses latched values after grant, so a change or drop of valid mid-txn does not affect it.
//  If a requester's valid is still 1 in the IDLE cycle after its own ready, that is treated as a new request.
//  wait_cnt is $clog2(MAX_WAIT+1) bits wide and saturates at MAX_WAIT.
// TESTING
//  1. Only I: i_req_valid=1, addr=0x0000_0040, rd; memory readies 2 cycles after ISSUE with data 0xDEAD_BEEF
//     -> mem_req_vaild=1 from cycle+1; i_req_ready=1 and i_rd_data=0xDEAD_BEEF in the ready cycle; d_req_ready stays 0.
//  2. Conflict after reset: I and D both valid in the same cycle
//     -> D served first; I served next, starting at the following IDLE.
//     -> With both held valid, the grant sequence is D,I,D,I.
//  3. RR_EN=0, both valid continuously -> D granted every time; I never granted.
//  4. D write: addr=0x0000_1230, data=0x1234_5678
//     -> mem_req_wr=1 and mem_wr_data=0x1234_5678, stable through WAIT even if d_wr_data changes after grant.
//  5. Memory stalls beyond MAX_WAIT=4
//     -> err_timeout pulses once, 4 cycles after entering WAIT; the txn completes normally on a later ready.
//  6. rst=0 asserted during WAIT
//     -> next cycle all outputs=0 and state=IDLE; no ready to either cache; after release, the first conflict goes to D.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between the I-cache and D-cache, one transaction
// outstanding at a time, with round-robin (or D-first) resolution of simultaneous requests.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter bit RR_EN    = 1'b1,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              i_req_ready,
   output logic [DATA_W-1:0] i_rd_data,
   input  logic              d_req_valid,
   input  logic              d_req_wr,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              d_req_ready,
   output logic [DATA_W-1:0] d_rd_data,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_req_vaild,
   output logic              mem_req_wr,
   input  logic [DATA_W-1:0] mem_req_data,
   input  logic              mem_req_ready,
   output logic              grant_d,
   output logic              err_timeout
);

   // state | meaning
   // IDLE  | no txn outstanding; arbitrate among valid requesters
   // ISSUE | winner latched, mem_req_vaild asserted for the first cycle
   // WAIT  | holding the request until mem_req_ready; counting wait cycles

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] wait_cnt;
   logic             pick_d;
   logic             done;

   always_comb begin
      pick_d = d_req_valid && (!i_req_valid || !RR_EN || !last_grant);
      done   = (state == WAIT) && mem_req_ready;
   end

   assign i_req_ready = done && !grant_d;
   assign d_req_ready = done && grant_d;
   assign i_rd_data   = i_req_ready ? mem_req_data : '0;
   assign d_rd_data   = d_req_ready ? mem_req_data : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         last_grant    <= 1'b0;
         wait_cnt      <= '0;
         mem_req_addr  <= '0;
         mem_wr_data   <= '0;
         mem_req_vaild <= 1'b0;
         mem_req_wr    <= 1'b0;
         grant_d       <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_valid || d_req_valid) begin
                  grant_d       <= pick_d;
                  mem_req_addr  <= pick_d ? d_req_addr : i_req_addr;
                  mem_wr_data   <= pick_d ? d_wr_data  : i_wr_data;
                  mem_req_wr    <= pick_d ? d_req_wr   : i_req_wr;
                  mem_req_vaild <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (mem_req_ready) begin
                  mem_req_vaild <= 1'b0;
                  last_grant    <= grant_d;
                  wait_cnt      <= '0;
                  state         <= IDLE;
               end else begin
                  // pulse lands in the cycle where the count reads MAX_WAIT; saturation keeps it single
                  if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == CNT_PRE) err_timeout <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester queues feed both caches, expected
// grants are queued in arbitration order and retired on each completion pulse.
module tb_mem_port_arbiter;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        i_req_valid = 1'b0, i_req_wr = 1'b0;
   logic [31:0] i_req_addr = '0, i_wr_data = '0;
   logic        i_req_ready;
   logic [31:0] i_rd_data;
   logic        d_req_valid = 1'b0, d_req_wr = 1'b0;
   logic [31:0] d_req_addr = '0, d_wr_data = '0;
   logic        d_req_ready;
   logic [31:0] d_rd_data;
   logic [31:0] mem_req_addr, mem_wr_data;
   logic        mem_req_vaild, mem_req_wr, grant_d, err_timeout;
   logic [31:0] mem_req_data = '0;
   logic        mem_req_ready = 1'b0;

   logic        f_i_req_valid = 1'b0, f_d_req_valid = 1'b0;
   logic        f_i_req_ready, f_d_req_ready;
   logic [31:0] f_i_rd_data, f_d_rd_data;
   logic [31:0] f_mem_req_addr, f_mem_wr_data;
   logic        f_mem_req_vaild, f_mem_req_wr, f_grant_d, f_err_timeout;
   logic [31:0] f_mem_req_data = '0;
   logic        f_mem_req_ready = 1'b0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_wr(i_req_wr), .i_req_addr(i_req_addr),
      .i_wr_data(i_wr_data), .i_req_ready(i_req_ready), .i_rd_data(i_rd_data),
      .d_req_valid(d_req_valid), .d_req_wr(d_req_wr), .d_req_addr(d_req_addr),
      .d_wr_data(d_wr_data), .d_req_ready(d_req_ready), .d_rd_data(d_rd_data),
      .mem_req_addr(mem_req_addr), .mem_wr_data(mem_wr_data),
      .mem_req_vaild(mem_req_vaild), .mem_req_wr(mem_req_wr),
      .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
      .grant_d(grant_d), .err_timeout(err_timeout)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0), .MAX_WAIT(255)) dut_fp (
      .clk(clk), .rst(rst),
      .i_req_valid(f_i_req_valid), .i_req_wr(1'b0), .i_req_addr(32'h0000_0500),
      .i_wr_data(32'h0), .i_req_ready(f_i_req_ready), .i_rd_data(f_i_rd_data),
      .d_req_valid(f_d_req_valid), .d_req_wr(1'b0), .d_req_addr(32'h0000_0600),
      .d_wr_data(32'h0), .d_req_ready(f_d_req_ready), .d_rd_data(f_d_rd_data),
      .mem_req_addr(f_mem_req_addr), .mem_wr_data(f_mem_wr_data),
      .mem_req_vaild(f_mem_req_vaild), .mem_req_wr(f_mem_req_wr),
      .mem_req_data(f_mem_req_data), .mem_req_ready(f_mem_req_ready),
      .grant_d(f_grant_d), .err_timeout(f_err_timeout)
   );

   typedef struct {
      bit          d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   txn_t sb[$];
   req_t iq[$];
   req_t dq[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   lat      = 2;
   bit   scramble = 1'b0;
   int   vcyc     = 0;
   int   err_cnt  = 0;
   logic vaild_prev = 1'b0;
   logic pos_req = 1'b0, pos_idle = 1'b0, pos_rst = 1'b0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input bit d, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
      req_t r;
      txn_t t;
      r.wr = wr; r.addr = addr; r.wdata = wd;
      t.d = d; t.wr = wr; t.addr = addr; t.wdata = wd; t.rdata = mem_val(addr);
      if (d) dq.push_back(r);
      else   iq.push_back(r);
      sb.push_back(t);
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (iq.size() == 0 && dq.size() == 0 && sb.size() == 0 && !mem_req_vaild) break;
         @(negedge clk); #1;
      end
      chk("drain_sb", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_vaild"}, 32'(mem_req_vaild), 32'd0);
      chk({pfx, "_addr"},  mem_req_addr, 32'd0);
      chk({pfx, "_wdata"}, mem_wr_data, 32'd0);
      chk({pfx, "_wr"},    32'(mem_req_wr), 32'd0);
      chk({pfx, "_grant"}, 32'(grant_d), 32'd0);
      chk({pfx, "_err"},   32'(err_timeout), 32'd0);
      chk({pfx, "_ready"}, {30'd0, i_req_ready, d_req_ready}, 32'd0);
      chk({pfx, "_rdata"}, i_rd_data | d_rd_data, 32'd0);
   endtask

   // memory model: completes after lat cycles of valid beyond the issue cycle
   initial begin
      int vcnt;
      vcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst || !mem_req_vaild) vcnt = 0;
         else vcnt++;
         if (rst && mem_req_vaild && vcnt == lat + 1) begin
            mem_req_ready = 1'b1;
            mem_req_data  = mem_val(mem_req_addr);
         end else begin
            mem_req_ready = 1'b0;
            mem_req_data  = $urandom;
         end
      end
   end

   // requester drivers: hold valid until own ready, then present the next queued request
   initial begin
      forever begin
         @(negedge clk);
         if (i_req_ready && iq.size() > 0) void'(iq.pop_front());
         if (d_req_ready && dq.size() > 0) void'(dq.pop_front());
         i_req_valid = (iq.size() > 0);
         if (iq.size() > 0) begin
            i_req_wr = iq[0].wr; i_req_addr = iq[0].addr; i_wr_data = iq[0].wdata;
         end
         d_req_valid = (dq.size() > 0);
         if (dq.size() > 0) begin
            d_req_wr = dq[0].wr; d_req_addr = dq[0].addr; d_wr_data = dq[0].wdata;
            if (scramble && mem_req_vaild && grant_d) begin
               d_req_wr = ~dq[0].wr; d_req_addr = $urandom; d_wr_data = $urandom;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         pos_req  = i_req_valid || d_req_valid;
         pos_idle = !mem_req_vaild;
         pos_rst  = rst;
      end
   end

   // monitor: issue, hold, timeout and completion checks against the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         if (!mem_req_vaild) vcyc = 0;
         else vcyc++;
         if (pos_rst && pos_idle && pos_req)
            chk("issue_latency", 32'(mem_req_vaild), 32'd1);
         if (mem_req_vaild && !vaild_prev) begin
            chk("issue_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               chk("issue_owner", 32'(grant_d), 32'(sb[0].d));
               chk("issue_addr",  mem_req_addr, sb[0].addr);
               chk("issue_wr",    32'(mem_req_wr), 32'(sb[0].wr));
               chk("issue_wdata", mem_wr_data, sb[0].wdata);
            end
         end else if (mem_req_vaild && sb.size() > 0) begin
            chk("hold_addr",  mem_req_addr, sb[0].addr);
            chk("hold_wr",    32'(mem_req_wr), 32'(sb[0].wr));
            chk("hold_wdata", mem_wr_data, sb[0].wdata);
         end
         if (err_timeout) begin
            err_cnt++;
            chk("err_cycle", 32'(vcyc), 32'(MW + 2));
         end
         if (i_req_ready || d_req_ready) begin
            chk("ready_onehot", 32'(i_req_ready && d_req_ready), 32'd0);
            chk("ready_pending", 32'(sb.size() > 0), 32'd1);
            chk("ready_cycle", 32'(vcyc), 32'(lat + 1));
            if (sb.size() > 0) begin
               chk("ready_owner", 32'(d_req_ready), 32'(sb[0].d));
               chk("rd_data", sb[0].d ? d_rd_data : i_rd_data, sb[0].rdata);
               chk("other_rd_data", sb[0].d ? i_rd_data : d_rd_data, 32'd0);
               void'(sb.pop_front());
            end
         end else begin
            chk("idle_rd_data", i_rd_data | d_rd_data, 32'd0);
         end
         vaild_prev = mem_req_vaild;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int fv;
      int fg;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_reset_outputs("reset");
      rst = 1'b1;

      // conflict straight after reset: D first, then alternating
      issue(1'b1, 1'b0, 32'h0000_0100, 32'h0);
      issue(1'b0, 1'b0, 32'h0000_0200, 32'h0);
      issue(1'b1, 1'b0, 32'h0000_0104, 32'h0);
      issue(1'b0, 1'b0, 32'h0000_0204, 32'h0);
      wait_idle(100);

      // I alone, read returning DEAD_BEEF
      issue(1'b0, 1'b0, 32'h0000_0040, 32'h0);
      wait_idle(50);

      // D write with inputs scrambled after grant
      scramble = 1'b1;
      issue(1'b1, 1'b1, 32'h0000_1230, 32'h1234_5678);
      wait_idle(50);
      scramble = 1'b0;
      chk("no_err_early", 32'(err_cnt), 32'd0);

      // memory stall past MAX_WAIT
      lat = 7;
      issue(1'b0, 1'b0, 32'h0000_0300, 32'h0);
      wait_idle(60);
      chk("err_count", 32'(err_cnt), 32'd1);
      lat = 2;

      // leave last_grant=D, then reset mid-WAIT: first conflict afterwards must still go to D
      issue(1'b1, 1'b0, 32'h0000_0400, 32'h0);
      wait_idle(50);
      lat = 10;
      issue(1'b1, 1'b0, 32'h0000_0404, 32'h0);
      for (int c = 0; c < 50 && vcyc != 3; c++) begin
         @(negedge clk); #1;
      end
      chk("reach_wait", 32'(vcyc), 32'd3);
      rst = 1'b0;
      sb.delete(); iq.delete(); dq.delete();
      @(negedge clk); #1;
      check_reset_outputs("midwait_rst");
      lat = 2;
      issue(1'b1, 1'b0, 32'h0000_0408, 32'h0);
      issue(1'b0, 1'b0, 32'h0000_0208, 32'h0);
      @(negedge clk); #1;
      check_reset_outputs("rst_hold");
      rst = 1'b1;
      wait_idle(100);
      chk("err_count_final", 32'(err_cnt), 32'd1);

      // fixed-priority instance, both held valid: only D is ever granted
      f_i_req_valid = 1'b1;
      f_d_req_valid = 1'b1;
      fv = 0;
      fg = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         fv = f_mem_req_vaild ? fv + 1 : 0;
         f_mem_req_ready = (fv == 3);
         f_mem_req_data  = 32'hF00D_0000 + 32'(c);
         @(negedge clk);
         if (f_mem_req_vaild && fv == 1) begin
            fg++;
            chk("fp_grant_d", 32'(f_grant_d), 32'd1);
         end
         chk("fp_i_ready", 32'(f_i_req_ready), 32'd0);
         if (f_d_req_ready) chk("fp_d_rd_data", f_d_rd_data, 32'hF00D_0000 + 32'(c));
      end
      chk("fp_grant_count", 32'(fg), 32'd10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
